// File: rtl/scc_pkg.sv
// Shared SCC f25 definitions: data-memory geometry and the dump engine state encoding.
package scc_pkg;

  localparam int SCC_DMEM_ADDR_W = 14;
  localparam int SCC_WORD_W      = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CSUM  = 3'd3,
    ST_DONE  = 3'd4
  } dump_state_e;

endpackage

// File: rtl/scc_dump_skid.sv
// Two-entry data+address FIFO that absorbs read data while the stream is stalled.
// Entry 0 is always the head, so the head outputs come straight from a register.
module scc_dump_skid
  import scc_pkg::*;
#(
  parameter int DATA_W = SCC_WORD_W,
  parameter int ADDR_W = SCC_DMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [ADDR_W-1:0] head_addr,
  output logic [1:0]        count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] data0_q, data1_q;
  logic [ADDR_W-1:0] addr0_q, addr1_q;
  logic [1:0]        count_q;
  logic              pop_ok;
  logic              push_ok;

  assign empty     = (count_q == 2'd0);
  assign full      = (count_q == 2'd2);
  assign count     = count_q;
  assign head_data = data0_q;
  assign head_addr = addr0_q;
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && (!full || pop_ok);

  // Shift/fill the two entries; a simultaneous push and pop keeps the occupancy.
  always_ff @(posedge clk) begin
    // NOTE: the storage is reset, not just the count, because the head drives
    // dump_data/dump_addr directly and those must read zero out of reset.
    if (rst) begin
      data0_q <= '0;
      data1_q <= '0;
      addr0_q <= '0;
      addr1_q <= '0;
      count_q <= 2'd0;
    end else if (en) begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count_q == 2'd0) begin
            data0_q <= push_data;
            addr0_q <= push_addr;
          end else begin
            data1_q <= push_data;
            addr1_q <= push_addr;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          data0_q <= data1_q;
          addr0_q <= addr1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            data0_q <= push_data;
            addr0_q <= push_addr;
          end else begin
            data0_q <= data1_q;
            addr0_q <= addr1_q;
            data1_q <= push_data;
            addr1_q <= push_addr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/scc_mem_dump.sv
// Post-halt data-memory dump engine: on a rising halt_f it reads START_ADDR..END_ADDR
// through a synchronous read port and streams every word on a valid/ready interface.
// Optional feature macro: SCC_DUMP_CHECKSUM_EN appends one 32-bit wrapping-sum beat.
module scc_mem_dump
  import scc_pkg::*;
#(
  parameter int          ADDR_W     = SCC_DMEM_ADDR_W,
  parameter int          DATA_W     = SCC_WORD_W,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned END_ADDR   = 16383
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              halt_f,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              dump_last,
  output logic              dump_busy,
  output logic              dump_done
);

  localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] END_A   = ADDR_W'(END_ADDR);

  if (END_ADDR < START_ADDR) begin : g_bad_range
    $error("scc_mem_dump: END_ADDR must be >= START_ADDR");
  end

  dump_state_e       state_q, state_d;
  logic              halt_q;
  logic              halt_rise;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic              inflight_q;
  logic [ADDR_W-1:0] inflight_addr_q;
  logic              issue;
  logic              pop;
  logic [DATA_W-1:0] head_data;
  logic [ADDR_W-1:0] head_addr;
  logic [1:0]        skid_count;
  logic              skid_full;
  logic              skid_empty;

  assign halt_rise   = halt_f && !halt_q;
  assign pop         = clk_en && dump_ready && !skid_empty;
  assign mem_rd_en   = issue;
  assign mem_rd_addr = rd_ptr_q;
  assign dump_busy   = (state_q == ST_READ) || (state_q == ST_DRAIN) || (state_q == ST_CSUM);
  assign dump_done   = (state_q == ST_DONE);

  // Read issue: only when the word can still land in the skid after this cycle's pop.
  always_comb begin
    issue = 1'b0;
    if (clk_en && (state_q == ST_READ) &&
        (({1'b0, skid_count} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2)) begin
      issue = 1'b1;
    end
  end

  // Next-state logic for the dump sequencer.
  always_comb begin
    // NOTE: state_d gets its hold value first so no path through the case leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (halt_rise) state_d = ST_READ;
      ST_READ:  if (issue && (rd_ptr_q == END_A)) state_d = ST_DRAIN;
      ST_DRAIN: if (skid_empty && !inflight_q) begin
`ifdef SCC_DUMP_CHECKSUM_EN
        state_d = ST_CSUM;
`else
        state_d = ST_DONE;
`endif
      end
`ifdef SCC_DUMP_CHECKSUM_EN
      ST_CSUM:  if (dump_ready) state_d = ST_DONE;
`endif
      ST_DONE:  if (!halt_f) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, halt edge detector, read pointer and in-flight read tracking.
  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all of them see the pre-edge values
    // of each other, exactly like the flops they describe.
    if (rst) begin
      state_q         <= ST_IDLE;
      halt_q          <= 1'b0;
      rd_ptr_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else if (clk_en) begin
      state_q    <= state_d;
      halt_q     <= halt_f;
      inflight_q <= issue;
      if (issue) inflight_addr_q <= rd_ptr_q;
      if ((state_q == ST_IDLE) && halt_rise) begin
        rd_ptr_q <= START_A;
      end else if (issue && (rd_ptr_q != END_A)) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  scc_dump_skid #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .en        (clk_en),
    .push      (inflight_q),
    .push_data (mem_rd_data),
    .push_addr (inflight_addr_q),
    .pop       (pop),
    .head_data (head_data),
    .head_addr (head_addr),
    .count     (skid_count),
    .full      (skid_full),
    .empty     (skid_empty)
  );

  // A returning read must never find the skid full without a pop in the same cycle.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(clk_en && inflight_q && skid_full && !pop));

`ifdef SCC_DUMP_CHECKSUM_EN
  logic [31:0] csum_q;

  // Running wrapping sum of every data beat actually transferred.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else if (clk_en) begin
      if ((state_q == ST_IDLE) && halt_rise) begin
        csum_q <= '0;
      end else if (pop) begin
        csum_q <= csum_q + 32'(head_data);
      end
    end
  end

  // Beat mux: skid head for data beats, accumulator for the trailing checksum beat.
  always_comb begin
    dump_valid = !skid_empty;
    dump_data  = head_data;
    dump_addr  = head_addr;
    dump_last  = 1'b0;
    if (state_q == ST_CSUM) begin
      dump_valid = 1'b1;
      dump_data  = DATA_W'(csum_q);
      dump_addr  = '0;
      dump_last  = 1'b1;
    end
  end
`else
  // Beat mux: the skid head is the beat; the END_ADDR word closes the dump.
  always_comb begin
    dump_valid = !skid_empty;
    dump_data  = head_data;
    dump_addr  = head_addr;
    dump_last  = !skid_empty && (head_addr == END_A);
  end
`endif

endmodule

// File: tb/tb_scc_mem_dump.sv
// Scoreboard bench for scc_mem_dump: three instances (full range, single word 100,
// range 0..3) share one clock; stimulus pushes expected beats, a monitor pops and compares.
`timescale 1ns/1ps
module tb_scc_mem_dump;
  import scc_pkg::*;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int NI = 3;
  localparam int unsigned S_ADDR [NI] = '{0, 100, 0};
  localparam int unsigned E_ADDR [NI] = '{16383, 100, 3};
  localparam logic [3:0] BP_PAT = 4'b1001;
`ifdef SCC_DUMP_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  typedef struct packed {
    logic [1:0]    inst;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]         rst, clk_en, halt_f, dump_ready;
  logic [NI-1:0]         mem_rd_en, dump_valid, dump_last, dump_busy, dump_done;
  logic [NI-1:0][AW-1:0] mem_rd_addr, dump_addr;
  logic [NI-1:0][DW-1:0] mem_rd_data, dump_data;

  int total = 0;
  int bad   = 0;

  beat_t exp_q[$];
  int    beats   [NI];
  int    issued  [NI];
  int    xfer    [NI];
  logic [AW-1:0] exp_rd [NI];
  logic [NI-1:0] prev_stall;
  beat_t prev_beat [NI];
  beat_t cur, e;

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return (a == AW'(100)) ? 32'h0000_0032 : DW'(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    scc_mem_dump #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .START_ADDR (S_ADDR[g]),
      .END_ADDR   (E_ADDR[g])
    ) u_dut (
      .clk         (clk),
      .rst         (rst[g]),
      .clk_en      (clk_en[g]),
      .halt_f      (halt_f[g]),
      .mem_rd_en   (mem_rd_en[g]),
      .mem_rd_addr (mem_rd_addr[g]),
      .mem_rd_data (mem_rd_data[g]),
      .dump_valid  (dump_valid[g]),
      .dump_ready  (dump_ready[g]),
      .dump_data   (dump_data[g]),
      .dump_addr   (dump_addr[g]),
      .dump_last   (dump_last[g]),
      .dump_busy   (dump_busy[g]),
      .dump_done   (dump_done[g])
    );

    // Synchronous read port model: data valid one enabled cycle after the strobe.
    always @(posedge clk) begin
      if (clk_en[g] && mem_rd_en[g]) mem_rd_data[g] <= mem_val(mem_rd_addr[g]);
    end
  end

  // Monitor: read-order / issue-limit checks, stall stability, scoreboard pops.
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (rst[g]) begin
        prev_stall[g] = 1'b0;
      end else begin
        if (!dump_busy[g]) begin
          exp_rd[g] = AW'(S_ADDR[g]);
          issued[g] = 0;
          xfer[g]   = 0;
        end
        if (clk_en[g] && mem_rd_en[g]) begin
          check("rd_issue_limit",
                64'((issued[g] - xfer[g] - ((dump_valid[g] && dump_ready[g]) ? 1 : 0)) < 2), 64'd1);
          check("rd_addr_order", 64'(mem_rd_addr[g]), 64'(exp_rd[g]));
          exp_rd[g] = exp_rd[g] + 1'b1;
          issued[g]++;
        end
        cur = '{inst: 2'(g), data: dump_data[g], addr: dump_addr[g], last: dump_last[g]};
        if (prev_stall[g]) begin
          check("stall_valid_held", 64'(dump_valid[g]), 64'd1);
          check("stall_beat_stable", 64'(cur), 64'(prev_beat[g]));
        end
        if (dump_valid[g] && dump_ready[g] && clk_en[g]) begin
          check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("beat", 64'(cur), 64'(e));
          end
          beats[g]++;
          xfer[g]++;
        end
        prev_stall[g] = dump_valid[g] && !(dump_ready[g] && clk_en[g]);
        prev_beat[g]  = cur;
      end
    end
  end

  task automatic push_expected(input int g);
    logic [31:0] sum;
    beat_t b;
    sum = '0;
    for (int unsigned a = S_ADDR[g]; a <= E_ADDR[g]; a++) begin
      b.inst = 2'(g);
      b.data = mem_val(AW'(a));
      b.addr = AW'(a);
      b.last = (CK == 0) && (a == E_ADDR[g]);
      exp_q.push_back(b);
      sum = sum + b.data;
    end
    if (CK != 0) exp_q.push_back('{inst: 2'(g), data: sum, addr: '0, last: 1'b1});
  endtask

  task automatic start_dump(input int g);
    @(posedge clk); #1;
    halt_f[g] = 1'b1;
    push_expected(g);
  endtask

  task automatic run_until_done(input int g, input int budget, input bit bp);
    int cyc;
    cyc = 0;
    while (!dump_done[g] && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      dump_ready[g] = bp ? BP_PAT[cyc % 4] : 1'b1;
    end
    check("done_in_budget", 64'(dump_done[g]), 64'd1);
    check("busy_clear_at_done", 64'(dump_busy[g]), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic rearm(input int g);
    halt_f[g] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rearm_idle", 64'(dump_done[g]), 64'd0);
  endtask

  task automatic check_reset_outputs(input int g);
    check("rst_mem_rd_en",   64'(mem_rd_en[g]),   64'd0);
    check("rst_mem_rd_addr", 64'(mem_rd_addr[g]), 64'd0);
    check("rst_dump_valid",  64'(dump_valid[g]),  64'd0);
    check("rst_dump_data",   64'(dump_data[g]),   64'd0);
    check("rst_dump_addr",   64'(dump_addr[g]),   64'd0);
    check("rst_dump_last",   64'(dump_last[g]),   64'd0);
    check("rst_dump_busy",   64'(dump_busy[g]),   64'd0);
    check("rst_dump_done",   64'(dump_done[g]),   64'd0);
  endtask

  initial begin
    int cyc;
    int base;
    logic [AW-1:0] snap_rd;
    logic [DW+AW+2:0] snap_out;

    for (int g = 0; g < NI; g++) begin
      beats[g] = 0;
      issued[g] = 0;
      xfer[g] = 0;
      exp_rd[g] = '0;
    end
    prev_stall = '0;
    rst        = '1;
    clk_en     = '1;
    halt_f     = '0;
    dump_ready = '1;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) check_reset_outputs(g);
    rst = '0;
    repeat (2) @(posedge clk);

    // Full dump, ready high, first-valid latency.
    start_dump(0);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!dump_valid[0] && cyc < 10);
    check("first_valid_latency", 64'(cyc), 64'd3);
    run_until_done(0, 20000, 1'b0);
    check("full_beat_count", 64'(beats[0]), 64'(16384 + CK));
    rearm(0);

    // Same dump under 1,0,0,1 backpressure.
    start_dump(0);
    dump_ready[0] = 1'b1;
    run_until_done(0, 40000, 1'b1);
    check("bp_beat_count", 64'(beats[0]), 64'(2 * (16384 + CK)));
    dump_ready[0] = 1'b1;
    rearm(0);

    // Reset after beat 50, then restart from address 0.
    base = beats[0];
    start_dump(0);
    cyc = 0;
    while (beats[0] < base + 50 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reached_beat_50", 64'(beats[0] - base), 64'd50);
    rst[0] = 1'b1;
    dump_ready[0] = 1'b0;
    halt_f[0] = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check_reset_outputs(0);
    rst[0] = 1'b0;
    dump_ready[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("no_beats_after_reset", 64'(beats[0] - base), 64'd50);

    // Restart with a 5-cycle clock-enable gap mid-dump.
    base = beats[0];
    start_dump(0);
    cyc = 0;
    while (beats[0] < base + 20 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    clk_en[0] = 1'b0;
    snap_rd  = mem_rd_addr[0];
    snap_out = {dump_valid[0], dump_busy[0], dump_last[0], dump_data[0], dump_addr[0]};
    repeat (5) begin
      @(posedge clk); #1;
      check("gap_rd_en_low", 64'(mem_rd_en[0]), 64'd0);
      check("gap_rd_ptr_frozen", 64'(mem_rd_addr[0]), 64'(snap_rd));
      check("gap_outputs_frozen",
            64'({dump_valid[0], dump_busy[0], dump_last[0], dump_data[0], dump_addr[0]}), 64'(snap_out));
    end
    clk_en[0] = 1'b1;
    run_until_done(0, 20000, 1'b0);
    check("restart_beat_count", 64'(beats[0] - base), 64'(16384 + CK));
    halt_f[0] = 1'b0;

    // Single word at 100, halt held high, then exactly one repeat.
    start_dump(1);
    run_until_done(1, 100, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("held_halt_done", 64'(dump_done[1]), 64'd1);
    check("held_halt_no_beats", 64'(beats[1]), 64'(1 + CK));
    rearm(1);
    start_dump(1);
    run_until_done(1, 100, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("single_repeat_count", 64'(beats[1]), 64'(2 * (1 + CK)));
    halt_f[1] = 1'b0;

    // Range 0..3 (checksum beat 0x6 when the feature is built in).
    start_dump(2);
    dump_ready[2] = 1'b1;
    run_until_done(2, 200, 1'b1);
    check("small_beat_count", 64'(beats[2]), 64'(4 + CK));

    repeat (5) @(posedge clk);
    check("total_beats_inst0", 64'(beats[0]), 64'(3 * (16384 + CK) + 50));
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scc_mem_dump.md
# scc_mem_dump

Post-halt data-memory dump engine for the SCC f25 processor. It sits directly downstream of `scc_f25_top`. When the core raises `halt_f`, the block walks a configurable word-address range of data memory through a dedicated synchronous read port. It streams each word out on a valid/ready interface for a file writer, UART bridge or bench monitor. This makes the final memory image, such as `scc_out.txt`, available without hierarchical peeking.

## Interface
Parameters:
- `ADDR_W`, 14: data-memory word-address width (16384 words).
- `DATA_W`, 32: data word width.
- `START_ADDR`, 0: first word address dumped.
- `END_ADDR`, 16383: last word address dumped. Must satisfy `END_ADDR >= START_ADDR`; violating this is an elaboration error.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `clk_en` in 1: global clock enable. When low, all state holds.
- `halt_f` in 1: core halt flag.
- `mem_rd_en` out 1: data-memory read strobe.
- `mem_rd_addr` out ADDR_W: read word address.
- `mem_rd_data` in DATA_W: read data, valid exactly 1 enabled cycle after `mem_rd_en`.
- `dump_valid` out 1: stream beat valid.
- `dump_ready` in 1: downstream accepts the beat.
- `dump_data` out DATA_W: beat data.
- `dump_addr` out ADDR_W: word address of the beat.
- `dump_last` out 1: final beat of the dump.
- `dump_busy` out 1: dump in progress.
- `dump_done` out 1: dump complete, held.

## Operation
State machine: IDLE → READ → DRAIN → (CSUM) → DONE.
- **IDLE:** tracks `halt_f`. On a sampled 0→1 edge of `halt_f`, go to READ with the read pointer at `START_ADDR`.
- **READ:** issues one read per enabled cycle while `stored + inflight - pop < 2`. The read pointer increments on each issue. The read at `END_ADDR` moves the FSM to DRAIN.
- **DRAIN:** waits until the skid buffer is empty and no read is in flight.
- **CSUM** (macro only): presents a single checksum beat.
- **DONE:** `dump_done`=1. The FSM returns to IDLE only when `halt_f` is low, which re-arms it. `halt_f` held high never causes a second dump.

Stream rules:
- A beat transfers when `dump_valid && dump_ready`.
- While `dump_valid && !dump_ready`, `dump_data`, `dump_addr` and `dump_last` hold stable. No word is lost or duplicated.

Signal rules:
- `dump_busy` = state ∈ {READ, DRAIN, CSUM}.
- `dump_addr` is the captured read address of the beat.
- The address counter is ADDR_W bits and never wraps inside a dump, because `END_ADDR` bounds it.

Other behaviour:
- `halt_f` falling mid-dump is ignored; the dump completes.
- `rst` mid-dump aborts on the next edge, discards any in-flight read, and returns to IDLE. A fresh `halt_f` 0→1 edge is required to start again.
- Reset values: `mem_rd_en`=0, `mem_rd_addr`=0, `dump_valid`=0, `dump_data`=0, `dump_addr`=0, `dump_last`=0, `dump_busy`=0, `dump_done`=0. The edge detector resets to 0, so `halt_f` high out of reset triggers a dump.

## Timing
- **Edge to first read:** the `halt_f` edge sampled at cycle N → first `mem_rd_en` at N+1.
- **First beat:** `mem_rd_data` is captured into the skid at N+2, and the earliest `dump_valid` is at N+3.
- **Read latency:** read issue to beat valid is 2 cycles.
- **Throughput:** 1 beat/cycle sustained with `dump_ready` held high. Total dump ≈ (END−START+1) + 3 cycles (+1 with checksum).
- **Re-read on ready drop:** `dump_ready` deasserting stalls reads, with at most 2 words buffered. No re-read occurs.
- **Clock enable:** every cycle count above is in `clk_en`-high cycles.

## Configuration
Macro: `SCC_DUMP_CHECKSUM_EN`.
- **Defined:**
  - The block keeps a running 32-bit wrapping sum of all data beats.
  - After the `END_ADDR` beat it emits one extra beat with `dump_data` = sum and `dump_addr` = 0.
  - `dump_last` is asserted on the checksum beat only.
- **Undefined:**
  - No CSUM state and no accumulator.
  - `dump_last` is asserted on the `END_ADDR` beat.

## Structure
- **Shared package `scc_pkg`:**
  - The dump state enum (IDLE/READ/DRAIN/CSUM/DONE).
  - `SCC_DMEM_ADDR_W`=14 and `SCC_WORD_W`=32.
- **Sub-module `scc_dump_skid`:** a 2-entry data+address FIFO. It exposes `push`, `pop`, `count`, `full`, `empty` and the head outputs.

## Test plan
Memory preload for all scenarios: `mem[i]=i` except `mem[100]=0x00000032`.
- **Full dump, `dump_ready`=1:**
  - Exactly 16384 beats, in address order.
  - The beat at addr 100 carries 0x00000032.
  - First `dump_valid` 3 cycles after the `halt_f` edge.
  - `dump_last` on addr 16383 (no macro).
- **Backpressure, `dump_ready` toggling 1,0,0,1 pattern:**
  - Identical beat sequence to the full-dump case.
  - Outputs stable during every valid&!ready cycle.
  - `mem_rd_en` never issues with 2 words already buffered.
- **Checksum, START=0, END=3, macro defined:**
  - Beats 0,1,2,3, then a checksum beat of 0x00000006.
  - `dump_last` only on the checksum beat.
  - Without the macro: 4 beats, `dump_last` at addr 3.
- **Reset mid-dump, `rst` after beat 50:**
  - All outputs at reset values next cycle; no further beats.
  - `halt_f` 0→1 afterwards restarts the dump at addr 0.
- **Clock enable gap, `clk_en` low for 5 cycles mid-dump:**
  - State, outputs and read pointer frozen.
  - Resumes with no loss or duplication.
- **Single word, START=END=100:**
  - One beat 0x00000032 with `dump_last`, then `dump_done`=1.
  - `halt_f` held high: no further beats.
  - `halt_f` low then high: exactly one repeat dump.
